// File: rtl/rcv_pack_fifo_if.sv
// Handshake/bus bundle for rcv_pack_fifo: word producer side, packed-entry consumer side and status.
interface rcv_pack_fifo_if #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_ENTRY = 4,
  parameter int DEPTH           = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PW    = $clog2(WORDS_PER_ENTRY);

  logic [WORD_W-1:0]                 wdata;
  logic                              enq_word;
  logic                              deq;
  logic                              fix_error;
  logic                              flush;
  logic [WORD_W*WORDS_PER_ENTRY-1:0] rdata;
  logic                              full;
  logic                              empty;
  logic [CNT_W-1:0]                  count;
  logic [PW-1:0]                     partial_cnt;
  logic                              framing_error;
  logic                              overflow;
  logic                              underflow;

  modport master (
    output wdata, enq_word, deq, fix_error, flush,
    input  rdata, full, empty, count, partial_cnt, framing_error, overflow, underflow
  );

  modport slave (
    input  wdata, enq_word, deq, fix_error, flush,
    output rdata, full, empty, count, partial_cnt, framing_error, overflow, underflow
  );
endinterface

// File: rtl/rcv_pack_fifo.sv
// Packing FIFO: assembles WORDS_PER_ENTRY input words in place in the tail slot, then commits the
// whole entry; show-ahead head output, framing/overflow/underflow status.
module rcv_pack_fifo #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_ENTRY = 4,
  parameter int DEPTH           = 4
) (
  input  logic           clk,
  input  logic           rst,
  rcv_pack_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PW    = $clog2(WORDS_PER_ENTRY);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PW-1:0]    r_partial;
  logic             r_framing_error;
  logic             r_overflow;
  logic             r_underflow;
  logic [WORDS_PER_ENTRY-1:0][WORD_W-1:0] r_mem [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_enq_ok;
  logic             w_last_word;
  logic             w_commit;
  logic             w_deq_ok;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == {CNT_W{1'b0}});
  // flush and fix_error both discard a concurrent word
  assign w_enq_ok    = bus.enq_word & ~w_full & ~bus.fix_error & ~bus.flush;
  assign w_last_word = (r_partial == PW'(WORDS_PER_ENTRY - 1));
  assign w_commit    = w_enq_ok & w_last_word;
  assign w_deq_ok    = bus.deq & ~w_empty & ~bus.flush;

  // Next entry count from concurrent commit/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_commit, w_deq_ok})
      2'b10:   w_count_nxt = r_count + CNT_W'(1'b1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state: pointers, counters, sticky and pulsed status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head          <= {PTR_W{1'b0}};
      r_tail          <= {PTR_W{1'b0}};
      r_count         <= {CNT_W{1'b0}};
      r_partial       <= {PW{1'b0}};
      r_framing_error <= 1'b0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
    end else if (bus.flush) begin
      r_head          <= {PTR_W{1'b0}};
      r_tail          <= {PTR_W{1'b0}};
      r_count         <= {CNT_W{1'b0}};
      r_partial       <= {PW{1'b0}};
      r_framing_error <= 1'b0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
    end else begin
      r_overflow  <= bus.enq_word & w_full & ~bus.fix_error;
      r_underflow <= bus.deq & w_empty;
      r_count     <= w_count_nxt;
      if (w_commit) begin
        r_tail <= r_tail + PTR_W'(1'b1);
      end
      if (w_deq_ok) begin
        r_head <= r_head + PTR_W'(1'b1);
      end
      if (bus.fix_error) begin
        r_partial <= {PW{1'b0}};
      end else if (w_enq_ok) begin
        r_partial <= w_last_word ? {PW{1'b0}} : r_partial + PW'(1'b1);
      end
      // consumer asked for data while only a partial entry was being built
      if (bus.fix_error) begin
        r_framing_error <= 1'b0;
      end else if (bus.deq && w_empty && (r_partial != {PW{1'b0}})) begin
        r_framing_error <= 1'b1;
      end
    end
  end

  // Storage: words land directly in the tail slot, no reset needed
  always_ff @(posedge clk) begin
    if (!rst && w_enq_ok) begin
      r_mem[r_tail][r_partial] <= bus.wdata;
    end
  end

  assign bus.rdata         = w_empty ? {(WORD_W*WORDS_PER_ENTRY){1'b0}} : r_mem[r_head];
  assign bus.full          = w_full;
  assign bus.empty         = w_empty;
  assign bus.count         = r_count;
  assign bus.partial_cnt   = r_partial;
  assign bus.framing_error = r_framing_error;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;
endmodule

// File: tb/tb_rcv_pack_fifo.sv
// Directed bench for rcv_pack_fifo: default 32x4x4 instance plus an 8x2x8 instance.
module tb_rcv_pack_fifo;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rcv_pack_fifo_if #(.WORD_W(32), .WORDS_PER_ENTRY(4), .DEPTH(4)) ifa ();
  rcv_pack_fifo_if #(.WORD_W(8),  .WORDS_PER_ENTRY(2), .DEPTH(8)) ifb ();

  rcv_pack_fifo #(.WORD_W(32), .WORDS_PER_ENTRY(4), .DEPTH(4)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  rcv_pack_fifo #(.WORD_W(8),  .WORDS_PER_ENTRY(2), .DEPTH(8)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_a(input logic [31:0] w);
    ifa.wdata = w; ifa.enq_word = 1'b1;
    tick();
    ifa.enq_word = 1'b0;
  endtask

  task automatic deq_a();
    ifa.deq = 1'b1;
    tick();
    ifa.deq = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] base);
    for (int i = 0; i < 4; i++) enq_a(base + 32'(i));
  endtask

  function automatic logic [127:0] ent(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  initial begin
    ifa.wdata = 32'h0; ifa.enq_word = 1'b0; ifa.deq = 1'b0; ifa.fix_error = 1'b0; ifa.flush = 1'b0;
    ifb.wdata = 8'h0;  ifb.enq_word = 1'b0; ifb.deq = 1'b0; ifb.fix_error = 1'b0; ifb.flush = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_empty", ifa.empty, 1'b1);
    chk("rst_full", ifa.full, 1'b0);
    chk("rst_count", ifa.count, 3'd0);
    chk("rst_partial", ifa.partial_cnt, 2'd0);
    chk("rst_rdata", ifa.rdata, 128'h0);
    chk("rst_ferr", ifa.framing_error, 1'b0);
    chk("rst_ovf", ifa.overflow, 1'b0);
    chk("rst_unf", ifa.underflow, 1'b0);

    // first packed entry
    enq_a(32'h11111111); enq_a(32'h22222222);
    chk("part2_partial", ifa.partial_cnt, 2'd2);
    chk("part2_empty", ifa.empty, 1'b1);
    enq_a(32'h33333333); enq_a(32'h44444444);
    chk("e1_empty", ifa.empty, 1'b0);
    chk("e1_count", ifa.count, 3'd1);
    chk("e1_partial", ifa.partial_cnt, 2'd0);
    chk("e1_rdata", ifa.rdata, 128'h44444444_33333333_22222222_11111111);

    // fill, then overflow
    push_a(32'hA0); push_a(32'hB0); push_a(32'hC0);
    chk("fill_full", ifa.full, 1'b1);
    chk("fill_count", ifa.count, 3'd4);
    enq_a(32'hDEAD);
    chk("ovf_pulse", ifa.overflow, 1'b1);
    chk("ovf_count", ifa.count, 3'd4);
    chk("ovf_partial", ifa.partial_cnt, 2'd0);
    tick();
    chk("ovf_clear", ifa.overflow, 1'b0);

    // drain in order
    chk("pop1", ifa.rdata, 128'h44444444_33333333_22222222_11111111);
    deq_a();
    chk("pop2", ifa.rdata, ent(32'hA0));
    chk("pop2_full", ifa.full, 1'b0);
    deq_a();
    chk("pop3", ifa.rdata, ent(32'hB0));
    deq_a();
    chk("pop4", ifa.rdata, ent(32'hC0));
    deq_a();
    chk("drain_empty", ifa.empty, 1'b1);
    chk("drain_rdata", ifa.rdata, 128'h0);

    // pointer wrap with interleaved push/pop
    push_a(32'hD0); push_a(32'hE0);
    chk("wrap_d0", ifa.rdata, ent(32'hD0));
    deq_a();
    push_a(32'hF0); push_a(32'h100);
    chk("wrap_count", ifa.count, 3'd3);
    chk("wrap_e0", ifa.rdata, ent(32'hE0));
    deq_a();
    chk("wrap_f0", ifa.rdata, ent(32'hF0));
    deq_a();
    chk("wrap_100", ifa.rdata, ent(32'h100));
    deq_a();
    chk("wrap_empty", ifa.empty, 1'b1);

    // underflow with partial entry -> framing error
    enq_a(32'h1); enq_a(32'h2);
    deq_a();
    chk("unf_pulse", ifa.underflow, 1'b1);
    chk("unf_ferr", ifa.framing_error, 1'b1);
    chk("unf_partial", ifa.partial_cnt, 2'd2);
    enq_a(32'h3);
    chk("unf_clear", ifa.underflow, 1'b0);
    chk("ferr_sticky", ifa.framing_error, 1'b1);
    ifa.fix_error = 1'b1;
    tick();
    ifa.fix_error = 1'b0;
    chk("fix_ferr", ifa.framing_error, 1'b0);
    chk("fix_partial", ifa.partial_cnt, 2'd0);
    chk("fix_empty", ifa.empty, 1'b1);

    // fix_error discards a concurrent word
    enq_a(32'h77);
    ifa.wdata = 32'h88; ifa.enq_word = 1'b1; ifa.fix_error = 1'b1;
    tick();
    ifa.enq_word = 1'b0; ifa.fix_error = 1'b0;
    chk("fixenq_partial", ifa.partial_cnt, 2'd0);
    push_a(32'h500);
    chk("fixenq_rdata", ifa.rdata, ent(32'h500));
    deq_a();

    // commit and pop in the same cycle
    push_a(32'h200); push_a(32'h300);
    enq_a(32'h400); enq_a(32'h401); enq_a(32'h402);
    chk("cd_pre_count", ifa.count, 3'd2);
    ifa.wdata = 32'h403; ifa.enq_word = 1'b1; ifa.deq = 1'b1;
    tick();
    ifa.enq_word = 1'b0; ifa.deq = 1'b0;
    chk("cd_count", ifa.count, 3'd2);
    chk("cd_rdata", ifa.rdata, ent(32'h300));
    chk("cd_partial", ifa.partial_cnt, 2'd0);
    deq_a();
    chk("cd_next", ifa.rdata, ent(32'h400));
    deq_a();

    // flush with stored and partial data
    push_a(32'h600); push_a(32'h700); push_a(32'h800);
    enq_a(32'h900); enq_a(32'h901); enq_a(32'h902);
    ifa.flush = 1'b1; ifa.deq = 1'b1; ifa.enq_word = 1'b1;
    tick();
    ifa.flush = 1'b0; ifa.deq = 1'b0; ifa.enq_word = 1'b0;
    chk("flush_count", ifa.count, 3'd0);
    chk("flush_partial", ifa.partial_cnt, 2'd0);
    chk("flush_empty", ifa.empty, 1'b1);
    chk("flush_rdata", ifa.rdata, 128'h0);

    // reset mid-entry with framing error pending
    push_a(32'hA00);
    enq_a(32'hB00); enq_a(32'hB01);
    ifa.deq = 1'b1; tick(); ifa.deq = 1'b0;
    deq_a();
    chk("pre_rst_ferr", ifa.framing_error, 1'b1);
    ifa.wdata = 32'hB02; ifa.enq_word = 1'b1; ifa.deq = 1'b1; ifa.flush = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; ifa.enq_word = 1'b0; ifa.deq = 1'b0; ifa.flush = 1'b0;
    chk("mrst_count", ifa.count, 3'd0);
    chk("mrst_partial", ifa.partial_cnt, 2'd0);
    chk("mrst_ferr", ifa.framing_error, 1'b0);
    chk("mrst_unf", ifa.underflow, 1'b0);
    chk("mrst_ovf", ifa.overflow, 1'b0);
    chk("mrst_empty", ifa.empty, 1'b1);
    chk("mrst_full", ifa.full, 1'b0);
    chk("mrst_rdata", ifa.rdata, 128'h0);

    // narrow instance: 16 bytes into 8 two-byte entries
    for (int i = 1; i <= 16; i++) begin
      ifb.wdata = 8'(i); ifb.enq_word = 1'b1;
      tick();
    end
    ifb.enq_word = 1'b0;
    chk("b_full", ifb.full, 1'b1);
    chk("b_count", ifb.count, 4'd8);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] exp_e;
      exp_e = {8'(2 * k + 2), 8'(2 * k + 1)};
      chk($sformatf("b_entry%0d", k), ifb.rdata, exp_e);
      ifb.deq = 1'b1;
      tick();
      ifb.deq = 1'b0;
    end
    chk("b_empty", ifb.empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rcv_pack_fifo.md
RCV_PACK_FIFO -- requirements
Module: rcv_pack_fifo

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of one input word.
REQ-002 SHALL have parameter WORDS_PER_ENTRY, default 4, words packed into one FIFO entry; legal values 2..16.
REQ-003 SHALL have parameter DEPTH, default 4, number of packed entries; power of two, 2..64.
REQ-004 SHALL have port clk  input  1  rising-edge clock; sole clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wdata  input  WORD_W  word to pack; sampled in the cycle enq_word is high.
REQ-007 SHALL have port enq_word  input  1  request to append wdata to the entry being assembled.
REQ-008 SHALL have port deq  input  1  pop the head entry.
REQ-009 SHALL have port fix_error  input  1  discard the partial entry and clear framing_error.
REQ-010 SHALL have port flush  input  1  discard all stored and partial data.
REQ-011 SHALL have port rdata  output  WORD_W*WORDS_PER_ENTRY  head entry, show-ahead; word 0 in the LSBs.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  number of complete entries stored.
REQ-015 SHALL have port partial_cnt  output  clog2(WORDS_PER_ENTRY)  words held in the entry being assembled.
REQ-016 SHALL have port framing_error  output  1  sticky; consumer requested data while only a partial entry existed.
REQ-017 SHALL have port overflow  output  1  one-cycle pulse; enq_word dropped because full.
REQ-018 SHALL have port underflow  output  1  one-cycle pulse; deq ignored because empty.

Function
REQ-019 SHALL store words directly into the tail slot at word index partial_cnt; partial_cnt increments per accepted word.
REQ-020 SHALL accept enq_word only when full is low; when full, SHALL drop the word, leave all state unchanged and pulse overflow the next cycle.
REQ-021 SHALL, on the word making partial_cnt reach WORDS_PER_ENTRY, commit the entry: tail pointer advances (wrapping at DEPTH), count increments, partial_cnt returns to 0, all at the same clock edge.
REQ-022 SHALL make a committed entry visible on rdata, with empty low, in the cycle after the committing edge.
REQ-023 SHALL on deq with empty low advance the head pointer (wrapping at DEPTH) and decrement count.
REQ-024 SHALL on deq with empty high ignore the request and pulse underflow the next cycle.
REQ-025 SHALL, on deq with empty high and partial_cnt != 0, additionally set framing_error.
REQ-026 SHALL, on a committing enq_word and a valid deq in the same cycle, leave count unchanged while both pointers advance.
REQ-027 SHALL drive rdata to all zeros while empty is high.
REQ-028 SHALL on fix_error clear framing_error and set partial_cnt to 0; fix_error has priority over a concurrent enq_word, whose word is discarded; a concurrent deq proceeds normally.
REQ-029 SHALL on flush clear count, partial_cnt, both pointers and framing_error; flush has priority over enq_word, deq and fix_error.
REQ-030 SHALL keep framing_error high until fix_error, flush or rst, independent of later enq/deq activity.
REQ-031 SHALL not require reset of the storage array; only control state is reset.

Reset
REQ-032 SHALL, with rst high at a rising edge, set count=0, partial_cnt=0, pointers=0, framing_error=0, overflow=0, underflow=0; empty=1, full=0, rdata=0 from the next cycle.
REQ-033 SHALL give rst priority over every other input, including mid-entry assembly and flush.

Verification
REQ-034 SHALL cover: defaults, 4 words 0x11111111..0x44444444 enqueued -> one cycle after 4th word, empty=0, count=1, rdata=0x44444444_33333333_22222222_11111111.
REQ-035 SHALL cover: 16 words enqueued -> full=1, count=4; 17th word -> overflow pulse, count stays 4; 4 deqs return entries in order, wrap verified by 4 further entries.
REQ-036 SHALL cover: 2 words enqueued then deq while empty -> underflow pulse, framing_error=1, partial_cnt=2; fix_error -> framing_error=0, partial_cnt=0.
REQ-037 SHALL cover: count=2 with committing 4th word and deq in same cycle -> count stays 2, head data advances.
REQ-038 SHALL cover: 3 entries plus 3 partial words, flush -> count=0, partial_cnt=0, empty=1; rst asserted mid-entry -> all REQ-032 values next cycle.
REQ-039 SHALL cover: WORD_W=8, WORDS_PER_ENTRY=2, DEPTH=8 instance -> 16 words 0x01..0x10 yield 8 entries 0x0201..0x100F, full=1.
